// File: rtl/seven_segment_driver_if.sv
// Display-content bus feeding the seven-segment scanner: hex nibbles plus per-digit enables.
// Optional brightness field is present only when SEG7_BRIGHTNESS_EN is defined.
interface seven_segment_driver_if;
    logic [31:0] digit;
    logic [7:0]  en_dot;
    logic [7:0]  en_digit;
`ifdef SEG7_BRIGHTNESS_EN
    logic [2:0]  brightness;

    modport master (output digit, output en_dot, output en_digit, output brightness);
    modport slave  (input  digit, input  en_dot, input  en_digit, input  brightness);
`else
    modport master (output digit, output en_dot, output en_digit);
    modport slave  (input  digit, input  en_dot, input  en_digit);
`endif
endinterface

// File: rtl/seven_segment_driver.sv
// 8-digit multiplexed seven-segment scanner with per-slot blanking and per-frame input snapshot.
// Optional PWM-style dimming within the SHOW phase is enabled by defining SEG7_BRIGHTNESS_EN.
module seven_segment_driver #(
    parameter int unsigned  REFRESH_DIV = 100000,
    parameter int unsigned  BLANK_CYC   = 1000,
    localparam int unsigned CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seven_segment_driver_if.slave src_i,
    output logic [7:0]            an_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic                  frame_start_o,
    output logic                  dbg_state_o,
    output logic [CNT_W-1:0]      dbg_cnt_o,
    output logic [2:0]            dbg_idx_o
);

    if (REFRESH_DIV < 16) begin : g_bad_refresh_div
        $error("seven_segment_driver: REFRESH_DIV must be at least 16");
    end
    if ((BLANK_CYC < 1) || (BLANK_CYC >= REFRESH_DIV)) begin : g_bad_blank_cyc
        $error("seven_segment_driver: BLANK_CYC must be in [1, REFRESH_DIV)");
    end

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    // Slot position and digit index
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             slot_end;
    logic             frame_end;

    // Snapshot of the input bus, refreshed once per frame
    logic [31:0]      digit_q;
    logic [7:0]       en_dot_q;
    logic [7:0]       en_digit_q;
`ifdef SEG7_BRIGHTNESS_EN
    logic [2:0]       bright_q;
`endif

    state_e           state_q, state_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_start_q;

    logic [3:0]       nibble;
    logic             window_ok;
    logic             lit;

    // Active-high segment pattern {g,f,e,d,c,b,a} for a hex value.
    function automatic logic [6:0] hex_segments(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == 3'd7);
        cnt_d     = slot_end ? '0 : (cnt_q + CNT_W'(1));
        idx_d     = slot_end ? (idx_q + 3'd1) : idx_q;
        state_d   = (cnt_q < BLANK_END) ? ST_BLANK : ST_SHOW;
    end

`ifdef SEG7_BRIGHTNESS_EN
    localparam int unsigned ON_UNIT = (REFRESH_DIV - BLANK_CYC) >> 3;
    logic [CNT_W+3:0] on_len;
    logic [CNT_W+3:0] show_pos;

    // Only meaningful during SHOW; the subtraction wraps harmlessly in BLANK.
    always_comb begin
        on_len    = (CNT_W+4)'(ON_UNIT) * ((CNT_W+4)'(bright_q) + (CNT_W+4)'(1));
        show_pos  = (CNT_W+4)'(cnt_q - BLANK_END);
        window_ok = (show_pos < on_len);
    end
`else
    always_comb begin
        window_ok = 1'b1;
    end
`endif

    // A digit is driven only in SHOW, when enabled in the snapshot, and inside the dimming window.
    always_comb begin
        nibble = digit_q[{idx_q, 2'b00} +: 4];
        lit    = (state_d == ST_SHOW) && en_digit_q[idx_q] && window_ok;
        an_d   = lit ? ~(8'd1 << idx_q) : 8'hFF;
        seg_d  = lit ? ~hex_segments(nibble) : 7'h7F;
        dp_d   = lit ? ~en_dot_q[idx_q] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            state_q       <= ST_BLANK;
            an_q          <= 8'hFF;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
            digit_q       <= 32'h0;
            en_dot_q      <= 8'h00;
            en_digit_q    <= 8'h00;
`ifdef SEG7_BRIGHTNESS_EN
            bright_q      <= 3'd0;
`endif
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            state_q       <= state_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_end;
            if (frame_end) begin
                digit_q    <= src_i.digit;
                en_dot_q   <= src_i.en_dot;
                en_digit_q <= src_i.en_digit;
`ifdef SEG7_BRIGHTNESS_EN
                bright_q   <= src_i.brightness;
`endif
            end
        end
    end

    assign an_o          = an_q;
    assign seg_o         = seg_q;
    assign dp_o          = dp_q;
    assign frame_start_o = frame_start_q;
    assign dbg_state_o   = state_q;
    assign dbg_cnt_o     = cnt_q;
    assign dbg_idx_o     = idx_q;

endmodule

// File: tb/tb_seven_segment_driver.sv
// Directed bench for seven_segment_driver at REFRESH_DIV=16, BLANK_CYC=2.
// Also exercises the dimming window when built with SEG7_BRIGHTNESS_EN.
module tb_seven_segment_driver;

    localparam int R     = 16;
    localparam int B     = 2;
    localparam int FRAME = 8 * R;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] an_o;
    logic [6:0] seg_o;
    logic       dp_o;
    logic       frame_start_o;
    logic       dbg_state_o;
    logic [3:0] dbg_cnt_o;
    logic [2:0] dbg_idx_o;

    seven_segment_driver_if bus();

    seven_segment_driver #(
        .REFRESH_DIV (R),
        .BLANK_CYC   (B)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .src_i         (bus),
        .an_o          (an_o),
        .seg_o         (seg_o),
        .dp_o          (dp_o),
        .frame_start_o (frame_start_o),
        .dbg_state_o   (dbg_state_o),
        .dbg_cnt_o     (dbg_cnt_o),
        .dbg_idx_o     (dbg_idx_o)
    );

    always #5 clk = ~clk;

    int          n_checks     = 0;
    int          n_errors     = 0;
    int          cyc          = 0;
    int          overlap_errs = 0;
    int          lit_len      = R - B;
    logic [14:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Active-low segments from the hex table {g..a}.
    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] t;
        case (v)
            4'h0: t = 7'h3F; 4'h1: t = 7'h06; 4'h2: t = 7'h5B; 4'h3: t = 7'h4F;
            4'h4: t = 7'h66; 4'h5: t = 7'h6D; 4'h6: t = 7'h7D; 4'h7: t = 7'h07;
            4'h8: t = 7'h7F; 4'h9: t = 7'h6F; 4'hA: t = 7'h77; 4'hB: t = 7'h7C;
            4'hC: t = 7'h39; 4'hD: t = 7'h5E; 4'hE: t = 7'h79; default: t = 7'h71;
        endcase
        return ~t;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if ($countones(~an_o) > 1) overlap_errs++;
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_an"},  an_o,  8'hFF);
        check({tag, "_seg"}, seg_o, 7'h7F);
        check({tag, "_dp"},  dp_o,  1'b1);
    endtask

    // Called in cycle 0 after reset release; returns in cycle FRAME.
    task automatic first_frame(input string tag);
        int dark_errs;
        int fs_early;
        dark_errs = 0;
        fs_early  = 0;
        check({tag, "_cnt0"}, dbg_cnt_o, 4'd0);
        check({tag, "_idx0"}, dbg_idx_o, 3'd0);
        for (int i = 1; i < FRAME; i++) begin
            step();
            if (i == 1) check({tag, "_cnt1"}, dbg_cnt_o, 4'd1);
            if (i == 2) check({tag, "_state_blank"}, dbg_state_o, 1'b0);
            if (i == 3) check({tag, "_state_show"}, dbg_state_o, 1'b1);
            if (an_o !== 8'hFF || seg_o !== 7'h7F || dp_o !== 1'b1) dark_errs++;
            if (frame_start_o) fs_early++;
        end
        check({tag, "_frame_dark"}, dark_errs, 0);
        check({tag, "_fs_early"}, fs_early, 0);
        step();
        check({tag, "_fs_at_128"}, frame_start_o, 1'b1);
    endtask

    task automatic wait_frame_start();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            step();
            if (frame_start_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame_start_seen", ok, 1'b1);
    endtask

    // Current cycle must be the one where frame_start is high; returns at the next such cycle.
    task automatic run_frame(input string tag, input logic [31:0] d, input logic [7:0] en,
                             input logic [7:0] dot, input int change_at, input logic [31:0] new_digit);
        int         bad;
        int         fs_bad;
        int         p;
        int         slot;
        int         pos;
        bit         lit;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        bad    = 0;
        fs_bad = 0;
        for (int i = 1; i <= FRAME; i++) begin
            step();
            if (i == change_at) bus.digit = new_digit;
            p     = i - 1;
            slot  = p / R;
            pos   = p % R;
            lit   = en[slot] && (pos >= B) && ((pos - B) < lit_len);
            e_an  = lit ? ~(8'd1 << slot) : 8'hFF;
            e_seg = lit ? seg_of(d[4*slot +: 4]) : 7'h7F;
            e_dp  = lit ? ~dot[slot] : 1'b1;
            if ({an_o, seg_o, dp_o} !== {e_an, e_seg, e_dp}) begin
                if (bad == 0)
                    $display("  %s first divergence at frame cycle %0d: an=%h/%h seg=%h/%h dp=%b/%b",
                             tag, i, an_o, e_an, seg_o, e_seg, dp_o, e_dp);
                bad++;
            end
            if (frame_start_o !== (i == FRAME)) fs_bad++;
        end
        check({tag, "_bad_cycles"}, bad, 0);
        check({tag, "_fs_period"}, fs_bad, 0);
    endtask

    logic [6:0]  seg_hand [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    int          blank_run;
    int          lit_total;
    int          lit_starts;
    logic [14:0] exp_w;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.digit    = 32'h76543210;
        bus.en_digit = 8'hFF;
        bus.en_dot   = 8'h00;
`ifdef SEG7_BRIGHTNESS_EN
        bus.brightness = 3'd7;
        lit_len        = ((R - B) >> 3) * 8;
`endif
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_blank("reset");
            check("reset_fs", frame_start_o, 1'b0);
        end

        // Release mid-cycle: this negedge is cycle 0.
        rst_n = 1'b1;
        cyc   = 0;
        first_frame("por");

        // Second frame: digits 0..7 in order with a fixed blank gap before each.
        for (int k = 0; k < 8; k++) exp_q.push_back({~(8'd1 << k), seg_hand[k]});
        blank_run  = 0;
        lit_total  = 0;
        lit_starts = 0;
        for (int i = 1; i <= FRAME; i++) begin
            step();
            if (an_o === 8'hFF) begin
                blank_run++;
            end else begin
                if (blank_run != 0) begin
                    check("gap_blank_cycles", blank_run, (lit_starts == 0) ? B : (R - lit_len));
                    if (exp_q.size() > 0) begin
                        exp_w = exp_q.pop_front();
                        check("slot_an_seg", {an_o, seg_o}, exp_w);
                    end
                    check("slot_dp_off", dp_o, 1'b1);
                    lit_starts++;
                end
                blank_run = 0;
                lit_total++;
            end
        end
        check("slots_consumed", exp_q.size(), 0);
        check("slot_starts", lit_starts, 8);
        check("lit_cycles_total", lit_total, 8 * lit_len);

        // Enable masking: only digits 0 and 7 lit; dots requested everywhere.
        bus.digit    = 32'hF6543210;
        bus.en_digit = 8'h81;
        bus.en_dot   = 8'hFF;
        wait_frame_start();
        run_frame("mask", 32'hF6543210, 8'h81, 8'hFF, 0, 32'h0);

        // Tear-free: change digit during slot 3; old value holds for the whole frame.
        bus.digit    = 32'h76543210;
        bus.en_digit = 8'hFF;
        bus.en_dot   = 8'h00;
        wait_frame_start();
        run_frame("tear_old", 32'h76543210, 8'hFF, 8'h00, 3 * R + 6, 32'h89ABCDEF);
        run_frame("tear_new", 32'h89ABCDEF, 8'hFF, 8'h00, 0, 32'h0);

        // Reset while digit 4 is lit.
        for (int i = 0; i < 4 * R + B + 4; i++) step();
        check("pre_reset_an", an_o, 8'hEF);
        check("pre_reset_seg", seg_o, 7'h03);
        rst_n = 1'b0;
        #1;
        check_blank("async_reset");
        check("async_reset_cnt", dbg_cnt_o, 4'd0);
        check("async_reset_idx", dbg_idx_o, 3'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        first_frame("restart");

`ifdef SEG7_BRIGHTNESS_EN
        bus.brightness = 3'd0;
        lit_len        = 1;
        wait_frame_start();
        run_frame("bright0", 32'h89ABCDEF, 8'hFF, 8'h00, 0, 32'h0);
        bus.brightness = 3'd3;
        lit_len        = 4;
        wait_frame_start();
        run_frame("bright3", 32'h89ABCDEF, 8'hFF, 8'h00, 0, 32'h0);
        bus.brightness = 3'd7;
        lit_len        = 8;
        wait_frame_start();
        run_frame("bright7", 32'h89ABCDEF, 8'hFF, 8'h00, 0, 32'h0);
`endif

        check("no_anode_overlap", overlap_errs, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seven_segment_driver.md
# seven_segment_driver

Scans the 8-digit seven-segment display from the nibble/enable bus produced by the display-content logic: `digit` (8 hex nibbles), `en_dot`, `en_digit`. Time-multiplexes one digit at a time onto shared active-low cathodes and per-digit active-low anodes. Inserts a blanking gap between digits to suppress ghosting, and snapshots the input bus once per frame so a frame never tears. Sits between the display-content logic and the board pins.

## Interface
- `REFRESH_DIV`, 100000: cycles per digit slot (100 MHz clock gives 1 kHz per digit, 125 Hz frame). Must be ≥ 16.
- `BLANK_CYC`, 1000: cycles at the start of each slot with all anodes off. Must satisfy 1 ≤ BLANK_CYC < REFRESH_DIV.
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `digit` input 32: nibble k = `digit[4k+3:4k]` is the hex value for digit k; digit 0 is rightmost.
- `en_dot` input 8: bit k lights the decimal point of digit k.
- `en_digit` input 8: bit k enables digit k. A disabled digit stays dark for its whole slot.
- `brightness` input 3: only present with `SEG7_BRIGHTNESS_EN`. 0 is dimmest, 7 is full.
- `an` output 8: anodes, active-low, one-hot-low or all-high.
- `seg` output 7: cathodes {g,f,e,d,c,b,a}, active-low.
- `dp` output 1: decimal point, active-low.
- `frame_start` output 1: one-cycle pulse when a new snapshot is taken.

## Operation
- **Counters.**
  - `cnt` runs 0..REFRESH_DIV-1 and wraps to 0.
  - `idx` (3 bits) increments on each `cnt` wrap. It wraps 7→0.
- **Snapshot.** On the clock edge where `cnt` = REFRESH_DIV-1 and `idx` = 7, capture `digit`, `en_dot` and `en_digit` (and `brightness` when configured) into snapshot registers. Assert `frame_start` for the following cycle. Input changes at any other time are ignored until the next snapshot.
- **State machine, per slot.**
  - BLANK while `cnt` < BLANK_CYC: `an` = 8'hFF, `seg` = 7'h7F, `dp` = 1.
  - SHOW for the rest of the slot:
    - If snapshot `en_digit[idx]` = 1: `an` = ~(1<<idx), `seg` = decode(nibble idx), `dp` = ~en_dot[idx].
    - Otherwise the outputs keep their BLANK values.
- **Decode table.** Standard hex segments on a..g (active-low output):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Example: F gives `seg` = 7'b0001110.
- **Dot without digit.** A set `en_dot[k]` with `en_digit[k]` = 0 does not light the dot.
- **Slot timing.** Every slot has the same length whether the digit is enabled or not, so brightness is uniform.
- **Mid-operation reset.** When `rst_n` falls, all outputs go to their blank values immediately (asynchronously) and all state clears.

## Timing
- **Reset values:**
  - `an` = 8'hFF, `seg` = 7'h7F, `dp` = 1, `frame_start` = 0.
  - `cnt` = 0, `idx` = 0.
  - Snapshot cleared to 0, so the first frame after reset is fully dark.
- **Output registration.** `an`, `seg` and `dp` are registered. They reflect the `cnt`/`idx` of the previous cycle, a fixed 1-cycle lag.
- **Snapshot latency.** A new input value reaches the display at the first snapshot after it is applied: at most 8·REFRESH_DIV cycles, plus 1 for the registered output.
- **First real snapshot.** Occurs at the edge that ends cycle 8·REFRESH_DIV-1 after reset release.
- **Frame and digit periods.** Frame period is exactly 8·REFRESH_DIV cycles. `frame_start` has the same period. Digit k's anode is low for cycles [k·R+B+1, (k+1)·R] of each frame, where R = REFRESH_DIV and B = BLANK_CYC.
- **Overlap guarantee.** Two anodes are never low in the same cycle.

## Configuration
- **With `SEG7_BRIGHTNESS_EN` defined:**
  - The `brightness` port exists and is sampled with the snapshot.
  - Within SHOW, the digit is lit only while cnt − BLANK_CYC < ((REFRESH_DIV−BLANK_CYC)>>3)·(brightness+1).
  - For the rest of SHOW the outputs take their BLANK values.
  - brightness = 7 is equivalent to full-on except for the truncation remainder.
- **Without it:** no port; SHOW is lit for its full length.

## Test plan
Benches run with REFRESH_DIV=16 and BLANK_CYC=2.
- **Reset and first frame.** Hold `rst_n` low, then release with `digit`=32'h76543210 and `en_digit`=8'hFF.
  - Reset: `an`=FF and `seg`=7F throughout reset.
  - First frame (128 cycles after release): stays dark.
  - `frame_start` pulses at cycle 128.
  - Second frame: `an` steps FE, FD, …, 7F with `seg` 40, 79, 24, 30, 19, 12, 02, 78.
- **Blanking.** For every slot, check `an`=FF for exactly 2 cycles before the anode asserts, and that `an` is never two-low.
- **Enable masking.** `en_digit`=8'h81, `en_dot`=8'hFF, digit7=F.
  - Only slots 0 and 7 are lit; digit 7 shows `seg`=0E, `dp`=0.
  - Slots 1–6 keep `an`=FF and `dp`=1.
- **Tear-free update.** Change `digit` mid-frame during slot 3. No change appears until the slot-0 following the next `frame_start`.
- **Reset mid-SHOW.** Assert `rst_n` low while digit 4 is lit. `an`=FF combinationally in the same cycle, and `cnt`/`idx` restart at 0 after release.
- **SEG7_BRIGHTNESS_EN.** brightness=0 lights each enabled digit for 1 cycle per slot; brightness=3 lights it for 4 cycles; brightness=7 lights it for 8 cycles.
